// File: rtl/pe_group_sched.sv
// Job scheduler for one PE_Group: weight load, then per block psum load / input stream / result drain.
// Optional weight reuse across jobs is enabled by defining PE_SCHED_WEIGHT_REUSE_EN.
module pe_group_sched #(
    parameter int DataWidth     = 32,
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = 7,
    parameter int I_BlockCount  = 4,
    parameter int CntWidth      = 4,
    parameter int BlkWidth      = 2
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic                 KeepW,
    output logic                 Busy,
    output logic                 Done,
    output logic [2:0]           Phase,
    output logic [BlkWidth-1:0]  BlockIdx,
    input  logic                 S_W_Valid,
    output logic                 S_W_Rdy,
    input  logic [DataWidth-1:0] S_W_Data,
    input  logic                 S_I_Valid,
    output logic                 S_I_Rdy,
    input  logic [DataWidth-1:0] S_I_Data,
    input  logic                 S_O_Valid,
    output logic                 S_O_Rdy,
    input  logic [DataWidth-1:0] S_O_Data,
    output logic                 K_O_Valid,
    input  logic                 K_O_Rdy,
    output logic [DataWidth-1:0] K_O_Data,
    output logic                 W_DataInValid,
    input  logic                 W_DataInRdy,
    output logic [DataWidth-1:0] W_DataIn,
    output logic                 I_DataInValid,
    input  logic                 I_DataInRdy,
    output logic [DataWidth-1:0] I_DataIn,
    output logic                 O_DataInValid,
    input  logic                 O_DataInRdy,
    output logic [DataWidth-1:0] O_DataIn,
    input  logic                 O_DataOutValid,
    output logic                 O_DataOutRdy,
    input  logic [DataWidth-1:0] O_DataOut
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        LOAD_O   = 3'd2,
        STREAM_I = 3'd3,
        DRAIN_O  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [BlkWidth-1:0] LastBlk = BlkWidth'(I_BlockCount - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CntWidth-1:0] r_xfer_cnt;
    logic [BlkWidth-1:0] r_blk_idx;
    logic [CntWidth-1:0] w_last_cnt;
    logic                w_xfer;
    logic                w_term;
    logic                w_skip_w;
    logic                w_ph_w;
    logic                w_ph_o;
    logic                w_ph_i;
    logic                w_ph_k;

    assign w_ph_w = (r_state == LOAD_W);
    assign w_ph_o = (r_state == LOAD_O);
    assign w_ph_i = (r_state == STREAM_I);
    assign w_ph_k = (r_state == DRAIN_O);

    // Valid/ready: a word moves when valid and ready are both high on the gated pair; only the
    // active phase's pair can be high, and data buses pass through ungated.
    assign W_DataInValid = S_W_Valid & w_ph_w;
    assign S_W_Rdy       = W_DataInRdy & w_ph_w;
    assign O_DataInValid = S_O_Valid & w_ph_o;
    assign S_O_Rdy       = O_DataInRdy & w_ph_o;
    assign I_DataInValid = S_I_Valid & w_ph_i;
    assign S_I_Rdy       = I_DataInRdy & w_ph_i;
    assign K_O_Valid     = O_DataOutValid & w_ph_k;
    assign O_DataOutRdy  = K_O_Rdy & w_ph_k;

    assign W_DataIn = S_W_Data;
    assign I_DataIn = S_I_Data;
    assign O_DataIn = S_O_Data;
    assign K_O_Data = O_DataOut;

    always_comb begin
        w_xfer     = 1'b0;
        w_last_cnt = '0;
        case (r_state)
            LOAD_W: begin
                w_xfer     = W_DataInValid & W_DataInRdy;
                w_last_cnt = CntWidth'(W_PEGroupSize - 1);
            end
            LOAD_O: begin
                w_xfer     = O_DataInValid & O_DataInRdy;
                w_last_cnt = CntWidth'(O_PEGroupSize - 1);
            end
            STREAM_I: begin
                w_xfer     = I_DataInValid & I_DataInRdy;
                w_last_cnt = CntWidth'(I_PEGroupSize - 1);
            end
            DRAIN_O: begin
                w_xfer     = K_O_Valid & K_O_Rdy;
                w_last_cnt = CntWidth'(O_PEGroupSize - 1);
            end
            default: ;
        endcase
    end

    assign w_term = w_xfer & (r_xfer_cnt == w_last_cnt);

`ifdef PE_SCHED_WEIGHT_REUSE_EN
    logic r_wloaded;

    // An abort mid-load leaves the PE weights partial, so reuse is no longer safe.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wloaded <= 1'b0;
        end else if (Abort) begin
            if (w_ph_w) r_wloaded <= 1'b0;
        end else if (w_ph_w && w_term) begin
            r_wloaded <= 1'b1;
        end
    end

    assign w_skip_w = KeepW & r_wloaded;
`else
    logic w_unused;
    assign w_unused = KeepW;
    assign w_skip_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (Start) w_state_nxt = w_skip_w ? LOAD_O : LOAD_W;
                LOAD_W:   if (w_term) w_state_nxt = LOAD_O;
                LOAD_O:   if (w_term) w_state_nxt = STREAM_I;
                STREAM_I: if (w_term) w_state_nxt = DRAIN_O;
                DRAIN_O:  if (w_term) w_state_nxt = (r_blk_idx == LastBlk) ? DONE : LOAD_O;
                DONE:     w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        Busy     = (r_state != IDLE);
        Done     = (r_state == DONE);
        Phase    = r_state;
        BlockIdx = r_blk_idx;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_xfer_cnt <= '0;
            r_blk_idx  <= '0;
        end else begin
            if (Abort || (w_state_nxt != r_state)) r_xfer_cnt <= '0;
            else if (w_xfer)                        r_xfer_cnt <= r_xfer_cnt + CntWidth'(1);

            if (Abort)                                          r_blk_idx <= '0;
            else if ((r_state == IDLE) && Start)                r_blk_idx <= '0;
            else if (w_ph_k && w_term && (r_blk_idx != LastBlk)) r_blk_idx <= r_blk_idx + BlkWidth'(1);
        end
    end

endmodule
